multi_source_enumerator: RTL



---
 rtl/multi_source_enumerator.sv | 138 +++++++++++++
 1 files changed

// File: rtl/multi_source_enumerator.sv
// multi_source_enumerator
//   Accepts one predecessor-address mask per word, latches source-count
//   status flags, then streams each set tag index as one valid/ready beat.
//   An all-zero mask yields a single beat with out_src=0 flagged out_none.
// Ports
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : mask input handshake (in_mask, in_word)
//   out_valid/out_ready  : beat output handshake
//   out_src, out_word    : current tag index, latched word index
//   out_last, out_none   : final beat of mask, empty-mask beat marker
//   src_count            : popcount of last accepted mask
//   multiple_source      : src_count >= 2
//   no_source            : src_count == 0
module multi_source_enumerator #(
    parameter int POS_num      = 11,
    parameter int POS_num_bit  = 4,
    parameter int word_num_bit = 4,
    parameter int SCAN_DIR     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [POS_num-1:0]      in_mask,
    input  logic [word_num_bit-1:0] in_word,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [POS_num_bit-1:0]  out_src,
    output logic [word_num_bit-1:0] out_word,
    output logic                    out_last,
    output logic                    out_none,
    output logic [POS_num_bit-1:0]  src_count,
    output logic                    multiple_source,
    output logic                    no_source
);

    typedef enum logic [1:0] {IDLE, SCAN, EMPTY} state_t;

    state_t                  state_q, state_d;
    logic [POS_num-1:0]      residual_q, residual_d;
    logic [word_num_bit-1:0] word_q, word_d;
    logic [POS_num_bit-1:0]  count_q, count_d;
    logic                    multi_q, multi_d;
    logic                    none_q, none_d;

    logic [POS_num_bit-1:0]  in_pop;
    logic [POS_num_bit-1:0]  sel_src;
    logic                    one_left;
    logic                    accept;
    logic                    beat_done;

    // Popcount of the incoming mask; fits in POS_num_bit by construction.
    always_comb begin
        in_pop = '0;
        for (int unsigned i = 0; i < POS_num; i++) begin
            in_pop = in_pop + POS_num_bit'(in_mask[i]);
        end
    end

    // Priority pick over the residual: the last match in the loop wins, so
    // iterate from the far end toward the preferred end.
    always_comb begin
        sel_src = '0;
        for (int unsigned i = 0; i < POS_num; i++) begin
            if (SCAN_DIR == 0) begin
                if (residual_q[POS_num-1-i]) sel_src = POS_num_bit'(POS_num-1-i);
            end else begin
                if (residual_q[i]) sel_src = POS_num_bit'(i);
            end
        end
    end

    assign one_left = (residual_q != '0) &&
                      ((residual_q & (residual_q - POS_num'(1))) == '0);

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q != IDLE);
    assign out_src   = (state_q == SCAN) ? sel_src : '0;
    assign out_last  = (state_q == SCAN) ? one_left : (state_q == EMPTY);
    assign out_none  = (state_q == EMPTY);
    assign out_word        = word_q;
    assign src_count       = count_q;
    assign multiple_source = multi_q;
    assign no_source       = none_q;

    assign accept    = in_valid && in_ready;
    assign beat_done = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        word_d     = word_q;
        count_d    = count_q;
        multi_d    = multi_q;
        none_d     = none_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    residual_d = in_mask;
                    word_d     = in_word;
                    count_d    = in_pop;
                    multi_d    = (in_pop >= POS_num_bit'(2));
                    none_d     = (in_pop == '0);
                    state_d    = (in_mask == '0) ? EMPTY : SCAN;
                end
            end
            SCAN: begin
                if (beat_done) begin
                    residual_d = residual_q & ~(POS_num'(1) << sel_src);
                    if (one_left) state_d = IDLE;
                end
            end
            EMPTY: begin
                if (beat_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            residual_q <= '0;
            word_q     <= '0;
            count_q    <= '0;
            multi_q    <= 1'b0;
            none_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
            word_q     <= word_d;
            count_q    <= count_d;
            multi_q    <= multi_d;
            none_q     <= none_d;
        end
    end

endmodule
